// File: rtl/sdram_sched_pkg.sv
// -----------------------------------------------------------------------------
// sdram_sched_pkg
// Shared definitions for the SDRAM port scheduler: port index constants,
// FSM state encoding and a one-hot to index helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_sched_pkg;

    localparam logic [1:0] P_RD1 = 2'd0;
    localparam logic [1:0] P_RD2 = 2'd1;
    localparam logic [1:0] P_WR1 = 2'd2;
    localparam logic [1:0] P_WR2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } sched_state_e;

    // Convert a one-hot 4-bit grant into its port index (0 when no bit is set).
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = P_RD1;
            4'b0010: idx = P_RD2;
            4'b0100: idx = P_WR1;
            4'b1000: idx = P_WR2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Combinational 4-way round-robin arbiter. Grants the first requesting port
// found after the last-served index, scanning cyclically.
// Ports:
//   req_i  [3:0]  request vector
//   last_i [1:0]  index of the most recently served port
//   gnt_o  [3:0]  one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter4
    import sdram_sched_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [3:0] gnt_o
);

    logic       found_s;
    logic [1:0] idx_s;

    // Rotating priority scan: last_i+1 is highest priority, last_i itself lowest.
    always_comb begin
        gnt_o   = 4'b0000;
        found_s = 1'b0;
        idx_s   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx_s = 2'(last_i + 2'(k));
            if (!found_s && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/sdram_port_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_port_scheduler
// Shares one SDRAM burst controller between four FIFO ports
// (0=RD1, 1=RD2, 2=WR1, 3=WR2) using round-robin selection. Keeps a running
// burst address per port, issues one command at a time and waits for done.
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   RD_USED / WR_USED     FIFO fill levels (slice 0 = port RD1 / WR1)
//   PORT_ADDR/MAX/LEN     per-port start address, max address, burst length
//   PORT_LOAD             per-port address reload (also blocks issue)
//   CMD_VALID/READY       command handshake with the burst controller
//   CMD_WRITE/ADDR/LEN    command fields, registered
//   GRANT                 one-hot active port, held until CMD_DONE
//   CMD_DONE              one-cycle burst-complete pulse
// -----------------------------------------------------------------------------
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ASIZE = 23,
    parameter int LSIZE = 9,
    parameter int USIZE = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [2*USIZE-1:0]   RD_USED,
    input  logic [2*USIZE-1:0]   WR_USED,
    input  logic [4*ASIZE-1:0]   PORT_ADDR,
    input  logic [4*ASIZE-1:0]   PORT_MAX,
    input  logic [4*LSIZE-1:0]   PORT_LEN,
    input  logic [3:0]           PORT_LOAD,
    output logic                 CMD_VALID,
    input  logic                 CMD_READY,
    output logic                 CMD_WRITE,
    output logic [ASIZE-1:0]     CMD_ADDR,
    output logic [LSIZE-1:0]     CMD_LEN,
    output logic [3:0]           GRANT,
    input  logic                 CMD_DONE
);

    // Common width for comparing fill levels against burst lengths.
    localparam int CW = (USIZE > LSIZE) ? USIZE : LSIZE;

    sched_state_e       state_q;
    logic [1:0]         ptr_q;
    logic [1:0]         gidx_q;
    logic               cmd_valid_q;
    logic               cmd_write_q;
    logic [ASIZE-1:0]   cmd_addr_q;
    logic [LSIZE-1:0]   cmd_len_q;
    logic [3:0]         grant_q;

    logic [3:0]         elig_s;
    logic [3:0]         arb_gnt_s;
    logic [1:0]         sel_idx_s;
    logic               issue_s;
    logic               done_s;
    logic [4*ASIZE-1:0] cur_addr_s;

    // Read ports need room for a full burst; write ports need a full burst of data.
    for (genvar i = 0; i < 2; i++) begin : g_rd_elig
        assign elig_s[i] = (CW'(RD_USED[i*USIZE +: USIZE]) < CW'(PORT_LEN[i*LSIZE +: LSIZE]))
                         && (PORT_LEN[i*LSIZE +: LSIZE] != {LSIZE{1'b0}})
                         && !PORT_LOAD[i];
    end
    for (genvar i = 2; i < 4; i++) begin : g_wr_elig
        assign elig_s[i] = (CW'(WR_USED[(i-2)*USIZE +: USIZE]) >= CW'(PORT_LEN[i*LSIZE +: LSIZE]))
                         && (PORT_LEN[i*LSIZE +: LSIZE] != {LSIZE{1'b0}})
                         && !PORT_LOAD[i];
    end

    rr_arbiter4 u_arb (
        .req_i  (elig_s),
        .last_i (ptr_q),
        .gnt_o  (arb_gnt_s)
    );

    assign sel_idx_s = onehot_to_idx(arb_gnt_s);
    // Any PORT_LOAD, even on a non-requesting port, holds off a new grant.
    assign issue_s   = (state_q == IDLE) && (|elig_s) && !(|PORT_LOAD);
    assign done_s    = (state_q == BUSY) && CMD_DONE;

    // Per-port running address generators; a reload beats a completion update.
    for (genvar i = 0; i < 4; i++) begin : g_addr
        logic [ASIZE-1:0] addr_q;
        logic [ASIZE-1:0] len_ext_s;
        logic [ASIZE-1:0] limit_s;
        logic [ASIZE-1:0] adv_s;

        assign len_ext_s = ASIZE'(PORT_LEN[i*LSIZE +: LSIZE]);
        // Underflows when PORT_MAX < PORT_LEN, which forces a wrap every burst.
        assign limit_s   = PORT_MAX[i*ASIZE +: ASIZE] - len_ext_s;
        assign adv_s     = (addr_q < limit_s) ? (addr_q + len_ext_s)
                                              : PORT_ADDR[i*ASIZE +: ASIZE];

        // Address register: reset/reload to start, advance on own burst completion.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                addr_q <= PORT_ADDR[i*ASIZE +: ASIZE];
            end else if (PORT_LOAD[i]) begin
                addr_q <= PORT_ADDR[i*ASIZE +: ASIZE];
            end else if (done_s && (gidx_q == 2'(i))) begin
                addr_q <= adv_s;
            end else begin
                addr_q <= addr_q;
            end
        end

        assign cur_addr_s[i*ASIZE +: ASIZE] = addr_q;
    end

    // Scheduler FSM with registered command and grant outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd3;
            gidx_q      <= 2'd0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= {ASIZE{1'b0}};
            cmd_len_q   <= {LSIZE{1'b0}};
            grant_q     <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_s) begin
                        grant_q     <= arb_gnt_s;
                        gidx_q      <= sel_idx_s;
                        cmd_write_q <= sel_idx_s[1];
                        cmd_addr_q  <= cur_addr_s[sel_idx_s*ASIZE +: ASIZE];
                        cmd_len_q   <= PORT_LEN[sel_idx_s*LSIZE +: LSIZE];
                        cmd_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    if (CMD_READY) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= BUSY;
                    end else begin
                        state_q <= ISSUE;
                    end
                end
                BUSY: begin
                    if (CMD_DONE) begin
                        grant_q <= 4'b0000;
                        ptr_q   <= gidx_q;
                        state_q <= IDLE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                default: begin
                    cmd_valid_q <= 1'b0;
                    grant_q     <= 4'b0000;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign CMD_VALID = cmd_valid_q;
    assign CMD_WRITE = cmd_write_q;
    assign CMD_ADDR  = cmd_addr_q;
    assign CMD_LEN   = cmd_len_q;
    assign GRANT     = grant_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_scheduler
// Self-checking bench: table of single-cycle selection vectors applied from
// reset, then directed multi-cycle sequences (rotation, wrap, stall, reload,
// reset mid-burst).
// -----------------------------------------------------------------------------
module tb_sdram_port_scheduler;

    localparam int ASIZE = 23;
    localparam int LSIZE = 9;
    localparam int USIZE = 16;

    logic                 CLK = 1'b0;
    logic                 RESET_N = 1'b0;
    logic [2*USIZE-1:0]   RD_USED;
    logic [2*USIZE-1:0]   WR_USED;
    logic [4*ASIZE-1:0]   PORT_ADDR;
    logic [4*ASIZE-1:0]   PORT_MAX;
    logic [4*LSIZE-1:0]   PORT_LEN;
    logic [3:0]           PORT_LOAD = 4'b0000;
    logic                 CMD_VALID;
    logic                 CMD_READY = 1'b0;
    logic                 CMD_WRITE;
    logic [ASIZE-1:0]     CMD_ADDR;
    logic [LSIZE-1:0]     CMD_LEN;
    logic [3:0]           GRANT;
    logic                 CMD_DONE = 1'b0;

    logic [ASIZE-1:0] pa [4];
    logic [ASIZE-1:0] pm [4];
    logic [LSIZE-1:0] pl [4];
    logic [USIZE-1:0] ru [2];
    logic [USIZE-1:0] wu [2];
    logic [ASIZE-1:0] exp_addr [4];

    assign PORT_ADDR = {pa[3], pa[2], pa[1], pa[0]};
    assign PORT_MAX  = {pm[3], pm[2], pm[1], pm[0]};
    assign PORT_LEN  = {pl[3], pl[2], pl[1], pl[0]};
    assign RD_USED   = {ru[1], ru[0]};
    assign WR_USED   = {wu[1], wu[0]};

    int pass_cnt  = 0;
    int total_cnt = 0;

    sdram_port_scheduler #(.ASIZE(ASIZE), .LSIZE(LSIZE), .USIZE(USIZE)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .RD_USED   (RD_USED),
        .WR_USED   (WR_USED),
        .PORT_ADDR (PORT_ADDR),
        .PORT_MAX  (PORT_MAX),
        .PORT_LEN  (PORT_LEN),
        .PORT_LOAD (PORT_LOAD),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WRITE (CMD_WRITE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_LEN   (CMD_LEN),
        .GRANT     (GRANT),
        .CMD_DONE  (CMD_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] rd1, rd2, wr1, wr2;
        logic [8:0]  len0;
        logic [3:0]  load;
        logic        exp_valid;
        logic [3:0]  exp_grant;
        logic        exp_write;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_defaults();
        for (int i = 0; i < 4; i++) begin
            pa[i] = 23'h40 + 23'(i) * 23'h10000;
            pm[i] = pa[i] + 23'h1000;
            pl[i] = 9'd256;
        end
        ru[0] = 16'd256; ru[1] = 16'd256;
        wu[0] = 16'd0;   wu[1] = 16'd0;
        PORT_LOAD = 4'b0000;
        CMD_READY = 1'b0;
        CMD_DONE  = 1'b0;
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) exp_addr[i] = pa[i];
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!CMD_VALID && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        ok = CMD_VALID;
    endtask

    task automatic accept();
        CMD_READY = 1'b1;
        @(posedge CLK); #1;
        CMD_READY = 1'b0;
    endtask

    task automatic done_pulse();
        CMD_DONE = 1'b1;
        @(posedge CLK); #1;
        CMD_DONE = 1'b0;
    endtask

    // One full burst on the expected port, checking fields and the address model.
    task automatic run_burst(input int p, input string tag);
        bit ok;
        logic [ASIZE-1:0] lim;
        wait_valid(ok);
        chk({tag, " valid"}, {31'd0, ok}, 32'd1);
        chk({tag, " grant"}, {28'd0, GRANT}, 32'd1 << p);
        chk({tag, " write"}, {31'd0, CMD_WRITE}, (p >= 2) ? 32'd1 : 32'd0);
        chk({tag, " addr"}, {9'd0, CMD_ADDR}, {9'd0, exp_addr[p]});
        accept();
        chk({tag, " busy valid"}, {31'd0, CMD_VALID}, 32'd0);
        chk({tag, " busy grant"}, {28'd0, GRANT}, 32'd1 << p);
        done_pulse();
        chk({tag, " done grant"}, {28'd0, GRANT}, 32'd0);
        lim = pm[p] - ASIZE'(pl[p]);
        exp_addr[p] = (exp_addr[p] < lim) ? exp_addr[p] + ASIZE'(pl[p]) : pa[p];
    endtask

    initial begin
        bit ok;
        logic [ASIZE-1:0] wrap_seq [5];
        logic [ASIZE-1:0] hold_addr;
        wrap_seq[0] = 23'd0;   wrap_seq[1] = 23'd256; wrap_seq[2] = 23'd512;
        wrap_seq[3] = 23'd768; wrap_seq[4] = 23'd0;

        //           rd1     rd2     wr1     wr2     len0    load     v     grant    w
        vecs[0]  = '{16'd256, 16'd256, 16'd0,   16'd0,   9'd256, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[1]  = '{16'd0,   16'd256, 16'd0,   16'd0,   9'd256, 4'b0000, 1'b1, 4'b0001, 1'b0};
        vecs[2]  = '{16'd256, 16'd255, 16'd0,   16'd0,   9'd256, 4'b0000, 1'b1, 4'b0010, 1'b0};
        vecs[3]  = '{16'd256, 16'd256, 16'd256, 16'd0,   9'd256, 4'b0000, 1'b1, 4'b0100, 1'b1};
        vecs[4]  = '{16'd256, 16'd256, 16'd0,   16'd1000,9'd256, 4'b0000, 1'b1, 4'b1000, 1'b1};
        vecs[5]  = '{16'd0,   16'd0,   16'd300, 16'd300, 9'd256, 4'b0000, 1'b1, 4'b0001, 1'b0};
        vecs[6]  = '{16'd256, 16'd10,  16'd0,   16'd256, 9'd256, 4'b0000, 1'b1, 4'b0010, 1'b0};
        vecs[7]  = '{16'd256, 16'd256, 16'd256, 16'd256, 9'd256, 4'b0000, 1'b1, 4'b0100, 1'b1};
        vecs[8]  = '{16'd0,   16'd256, 16'd0,   16'd0,   9'd256, 4'b0001, 1'b0, 4'b0000, 1'b0};
        vecs[9]  = '{16'd0,   16'd256, 16'd0,   16'd0,   9'd256, 4'b1000, 1'b0, 4'b0000, 1'b0};
        vecs[10] = '{16'd0,   16'd256, 16'd0,   16'd0,   9'd0,   4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[11] = '{16'd255, 16'd256, 16'd255, 16'd0,   9'd256, 4'b0000, 1'b1, 4'b0001, 1'b0};
        vecs[12] = '{16'd256, 16'd256, 16'd255, 16'd0,   9'd256, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[13] = '{16'd99,  16'd256, 16'd0,   16'd0,   9'd100, 4'b0000, 1'b1, 4'b0001, 1'b0};
        vecs[14] = '{16'd100, 16'd256, 16'd0,   16'd0,   9'd100, 4'b0000, 1'b0, 4'b0000, 1'b0};

        // Reset state
        set_defaults();
        RESET_N = 1'b0;
        #12;
        chk("reset valid", {31'd0, CMD_VALID}, 32'd0);
        chk("reset grant", {28'd0, GRANT}, 32'd0);
        chk("reset write", {31'd0, CMD_WRITE}, 32'd0);
        chk("reset addr", {9'd0, CMD_ADDR}, 32'd0);
        chk("reset len", {23'd0, CMD_LEN}, 32'd0);

        // Table: selection one cycle after inputs become eligible, from reset
        for (int v = 0; v < 15; v++) begin
            set_defaults();
            apply_reset();
            ru[0] = vecs[v].rd1; ru[1] = vecs[v].rd2;
            wu[0] = vecs[v].wr1; wu[1] = vecs[v].wr2;
            pl[0] = vecs[v].len0;
            PORT_LOAD = vecs[v].load;
            @(posedge CLK); #1;
            chk($sformatf("vec%0d valid", v), {31'd0, CMD_VALID}, {31'd0, vecs[v].exp_valid});
            chk($sformatf("vec%0d grant", v), {28'd0, GRANT}, {28'd0, vecs[v].exp_grant});
            chk($sformatf("vec%0d write", v), {31'd0, CMD_WRITE}, {31'd0, vecs[v].exp_write});
            if (vecs[v].exp_valid) begin
                int p;
                p = (vecs[v].exp_grant == 4'b0001) ? 0 : (vecs[v].exp_grant == 4'b0010) ? 1 :
                    (vecs[v].exp_grant == 4'b0100) ? 2 : 3;
                chk($sformatf("vec%0d addr", v), {9'd0, CMD_ADDR}, {9'd0, pa[p]});
                chk($sformatf("vec%0d len", v), {23'd0, CMD_LEN}, {23'd0, pl[p]});
            end
        end

        // RD1 twice: second burst starts PORT_ADDR[0]+256
        set_defaults();
        apply_reset();
        ru[0] = 16'd0;
        run_burst(0, "rd1 b0");
        chk("rd1 model adv", {9'd0, exp_addr[0]}, {9'd0, 23'h40 + 23'd256});
        run_burst(0, "rd1 b1");

        // All four eligible: strict rotation 0,1,2,3,0,1,2,3
        set_defaults();
        apply_reset();
        ru[0] = 16'd0; ru[1] = 16'd0; wu[0] = 16'd512; wu[1] = 16'd512;
        for (int b = 0; b < 8; b++) run_burst(b % 4, $sformatf("rr b%0d", b));

        // WR1 wrap: 0,256,512,768,0
        set_defaults();
        pa[2] = 23'd0; pm[2] = 23'd1024;
        apply_reset();
        wu[0] = 16'd256;
        for (int b = 0; b < 5; b++) begin
            exp_addr[2] = wrap_seq[b];
            run_burst(2, $sformatf("wrap b%0d", b));
        end

        // Stall in ISSUE for 10 cycles; a CMD_DONE there must be ignored
        set_defaults();
        apply_reset();
        ru[0] = 16'd0; ru[1] = 16'd0; wu[0] = 16'd512; wu[1] = 16'd512;
        wait_valid(ok);
        chk("stall first valid", {31'd0, ok}, 32'd1);
        hold_addr = CMD_ADDR;
        chk("stall first addr", {9'd0, hold_addr}, {9'd0, pa[0]});
        for (int c = 0; c < 10; c++) begin
            CMD_DONE = (c == 5);
            @(posedge CLK); #1;
            CMD_DONE = 1'b0;
            chk($sformatf("stall c%0d", c), {CMD_VALID, GRANT, CMD_ADDR},
                {1'b1, 4'b0001, hold_addr});
        end
        accept();
        done_pulse();
        exp_addr[0] = pa[0] + 23'd256;
        run_burst(1, "after stall");

        // Reload in BUSY and coincident with CMD_DONE, then PORT_LOAD in IDLE blocks issue
        set_defaults();
        apply_reset();
        wu[0] = 16'd256;
        run_burst(2, "load b0");
        wait_valid(ok);
        chk("load b1 valid", {31'd0, ok}, 32'd1);
        chk("load b1 addr", {9'd0, CMD_ADDR}, {9'd0, pa[2] + 23'd256});
        accept();
        PORT_LOAD = 4'b0100;
        @(posedge CLK); #1;
        PORT_LOAD = 4'b0000;
        @(posedge CLK); #1;
        PORT_LOAD = 4'b0100;
        CMD_DONE  = 1'b1;
        @(posedge CLK); #1;
        CMD_DONE  = 1'b0;
        PORT_LOAD = 4'b0010;
        chk("load done grant", {28'd0, GRANT}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            chk($sformatf("load block c%0d", c), {27'd0, CMD_VALID, GRANT}, 32'd0);
        end
        PORT_LOAD = 4'b0000;
        wait_valid(ok);
        chk("reload valid", {31'd0, ok}, 32'd1);
        chk("reload grant", {28'd0, GRANT}, 32'h4);
        chk("reload addr", {9'd0, CMD_ADDR}, {9'd0, pa[2]});

        // Reset asserted during BUSY, released: first grant goes to port 0
        set_defaults();
        apply_reset();
        ru[0] = 16'd0; ru[1] = 16'd0; wu[0] = 16'd512; wu[1] = 16'd512;
        run_burst(0, "rst b0");
        wait_valid(ok);
        chk("rst b1 grant", {28'd0, GRANT}, 32'h2);
        accept();
        #3;
        RESET_N = 1'b0;
        #1;
        chk("rst async grant", {28'd0, GRANT}, 32'd0);
        chk("rst async valid", {31'd0, CMD_VALID}, 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        chk("rst after valid", {31'd0, CMD_VALID}, 32'd1);
        chk("rst after grant", {28'd0, GRANT}, 32'h1);
        chk("rst after addr", {9'd0, CMD_ADDR}, {9'd0, pa[0]});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sdram_port_scheduler.md
Name: sdram_port_scheduler

Overview:
- Round-robin scheduler that shares the SDRAM burst controller between four FIFO ports: 0=RD1, 1=RD2, 2=WR1, 3=WR2.
- Monitors FIFO fill levels and keeps one running burst address per port.
- Issues one burst command at a time to the controller and waits for its done pulse.
- Replaces fixed-priority selection, so no port can be starved.

Parameters:
ASIZE, 23, SDRAM word-address width
LSIZE, 9, burst-length width
USIZE, 16, FIFO used-word count width

Ports:
CLK  in  1  controller clock
RESET_N  in  1  reset
RD_USED  in  2*USIZE  write-side usedw of read FIFOs; [USIZE-1:0]=RD1
WR_USED  in  2*USIZE  read-side usedw of write FIFOs; [USIZE-1:0]=WR1
PORT_ADDR  in  4*ASIZE  per-port start address, slice i = port i
PORT_MAX  in  4*ASIZE  per-port max address
PORT_LEN  in  4*LSIZE  per-port burst length
PORT_LOAD  in  4  per-port address reload / FIFO clear
CMD_VALID  out  1  burst command valid
CMD_READY  in  1  controller idle, accepts command
CMD_WRITE  out  1  1=write burst, 0=read burst
CMD_ADDR  out  ASIZE  burst start address
CMD_LEN  out  LSIZE  burst length
GRANT  out  4  one-hot active port; drives FIFO rdreq/wrreq masks and data mux
CMD_DONE  in  1  one-cycle burst-complete pulse from controller

Behaviour:
- Reset: RESET_N is asynchronous and active-low; the block is clocked on CLK. All outputs reset to 0.
  - State register resets to IDLE.
  - Round-robin pointer resets to 3, so port 0 is checked first.
  - Each cur_addr[i] resets to PORT_ADDR slice i.
- Eligibility, evaluated combinationally every cycle:
  - Read port i: RD_USED[i] < PORT_LEN[i], PORT_LEN[i] != 0 and PORT_LOAD[i] == 0.
  - Write port i: WR_USED[i] >= PORT_LEN[i], PORT_LEN[i] != 0 and PORT_LOAD[i] == 0.
- FSM states: IDLE, ISSUE, BUSY.
  - IDLE: if any port is eligible and no PORT_LOAD bit is high, pick the first eligible port after the pointer, scanning cyclically.
  - IDLE capture: register GRANT, CMD_WRITE (1 for ports 2 and 3), CMD_ADDR = cur_addr[sel] and CMD_LEN = PORT_LEN[sel]. Set CMD_VALID=1 and go to ISSUE.
  - IDLE latency: one cycle from eligibility to CMD_VALID.
  - ISSUE: hold CMD_VALID and all CMD_* fields stable until CMD_READY=1. On that same edge, drop CMD_VALID and go to BUSY.
  - BUSY: GRANT stays asserted. On CMD_DONE:
    - update cur_addr of the granted port;
    - set pointer to the granted index;
    - clear GRANT;
    - return to IDLE.
  - The next grant can occur no earlier than one cycle after CMD_DONE.
- Address update on CMD_DONE for port g:
  - If cur_addr[g] < PORT_MAX[g] - PORT_LEN[g], then cur_addr[g] += PORT_LEN[g].
  - Otherwise cur_addr[g] = PORT_ADDR[g] (wrap).
  - Arithmetic is unsigned ASIZE bits; PORT_LEN is zero-extended.
  - If PORT_MAX < PORT_LEN, the subtraction underflows. The port then always wraps to its start address.
- PORT_LOAD[i] loads cur_addr[i] = PORT_ADDR[i] on any cycle. It has priority over a CMD_DONE update in the same cycle.
- PORT_LOAD on the granted port during ISSUE or BUSY: the burst completes normally and the reload wins, so there is no advance.
- CMD_DONE in IDLE or ISSUE is ignored.
- CMD_READY outside ISSUE is ignored.
- Reset asserted mid-burst returns the block to reset state immediately. GRANT=0 and the controller is reset by the same RESET_N.

Decomposition:
- Shared package sdram_sched_pkg holds:
  - port index constants P_RD1=0, P_RD2=1, P_WR1=2, P_WR2=3;
  - state encoding IDLE=0, ISSUE=1, BUSY=2.
- One sub-module: rr_arbiter4. Inputs are a 4-bit request vector and a 2-bit last pointer; the output is a one-hot grant (combinational priority rotate).
- The address generators stay inline as four identical register slices.

Test Plan:
- Port lengths all 256, RD_USED=0 for RD1 only, then CMD_READY=1 → CMD_VALID the cycle after eligibility, GRANT=0001, CMD_WRITE=0, CMD_ADDR=PORT_ADDR[0]. After CMD_DONE, cur_addr[0]=PORT_ADDR[0]+256.
- All four ports continuously eligible, 8 bursts → grant order 0,1,2,3,0,1,2,3 with no repeats before rotation.
- WR1 with PORT_ADDR=0, PORT_MAX=1024, len 256, 5 bursts → CMD_ADDR sequence 0,256,512,768,0.
- CMD_READY held 0 for 10 cycles in ISSUE → CMD_VALID and CMD_ADDR stay stable throughout, and no second grant is issued.
- PORT_LOAD[2] pulsed in BUSY and coincident with CMD_DONE → next WR1 CMD_ADDR equals PORT_ADDR[2]. A PORT_LOAD high in IDLE blocks issue.
- RESET_N low during BUSY, then released → GRANT=0, CMD_VALID=0, first grant after release goes to port 0.
